// File: rtl/ppc_pkg.sv
// Shared types and helpers for the PowerPC fetch front-end.
// IBM bit numbering in the spec maps to [63:0] here: bit 0 is the MSB.
package ppc_pkg;

  localparam int XLEN     = 64;
  localparam int INSTR_W  = 32;
  localparam int DWADDR_W = 61;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Big-endian word select: the lower address lives in the upper half of the doubleword.
  function automatic logic [INSTR_W-1:0] select_word(input logic [XLEN-1:0] pc,
                                                      input logic [XLEN-1:0] dword);
    logic [INSTR_W-1:0] w;
    if (pc[2]) begin
      w = dword[31:0];
    end else begin
      w = dword[63:32];
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// The head reads as zero while the queue is empty.
module fetch_queue
  import ppc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_data,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Simultaneous push and pop leave the occupancy unchanged at any count.
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end else begin
        count_d = count_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end else begin
      head = '0;
    end
    count = count_q;
  end

endmodule

// File: rtl/ppc_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues one word fetch per cycle,
// tracks the single in-flight request and queues {pc, instr} for decode.
module ppc_fetch
  import ppc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                mem_rd_en,
  output logic [DWADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]     mem_rd_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [INSTR_W-1:0]  d_instr,
  output logic [XLEN-1:0]     d_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] FULL_OCC = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   occupancy;
  logic             issue, push, pop, valid_out;
  fetch_entry_t     push_entry, head;

  always_comb begin
    // The in-flight slot is counted so a returning response always has room.
    occupancy = {1'b0, q_count} + {{CNT_W{1'b0}}, pend_valid_q};
    issue     = !reset && !halt && !redirect && (occupancy < FULL_OCC);
    valid_out = (q_count != '0) && !redirect;
    push      = pend_valid_q && !redirect;
    pop       = valid_out && d_ready;
    push_entry.pc    = pend_pc_q;
    push_entry.instr = select_word(pend_pc_q, mem_rd_data);

    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = issue;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~64'd3;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    if (issue) begin
      pend_pc_d = fetch_pc_q;
    end else begin
      pend_pc_d = pend_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= '0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_entry),
    .head      (head),
    .count     (q_count)
  );

  always_comb begin
    mem_rd_en   = issue;
    mem_rd_addr = fetch_pc_q[63:3];
    d_valid     = valid_out;
    d_instr     = head.instr;
    d_pc        = head.pc;
  end

endmodule

// File: tb/tb_ppc_fetch.sv
// Directed bench for ppc_fetch: a stimulus script queues expected deliveries,
// a monitor pops and compares on every decode handshake.
module tb_ppc_fetch;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_rd_en;
  logic [60:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [63:0] d_pc;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  ppc_fetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_instr     (d_instr),
    .d_pc        (d_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: the word at byte address p holds 0x38000001 + p/4.
  function automatic logic [31:0] word_at(input logic [63:0] p);
    return 32'h38000001 + 32'(p >> 2);
  endfunction

  // Instruction port: doubleword returned the cycle after the request.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= {word_at({mem_rd_addr, 3'b000}), word_at({mem_rd_addr, 3'b100})};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] pc, input logic [31:0] instr);
    sb_t e;
    e.pc = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (d_valid === 1'b1 && d_ready === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_deliver: got pc=%h instr=%h, required nothing", d_pc, d_instr);
        end else begin
          e = sb.pop_front();
          if (d_pc !== e.pc || d_instr !== e.instr) begin
            n_bad++;
            $display("FAIL deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                     d_pc, d_instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 64'd0; d_ready = 1'b1;
    mem_rd_data = 64'd0;
    #1 reset = 1'b1;
    tick(); mid();
    chk("rst_dvalid", d_valid, 0);
    chk("rst_rden", mem_rd_en, 0);
    chk("rst_dpc", d_pc, 0);
    chk("rst_dinstr", d_instr, 0);

    // Stream from reset with decode always ready; halt after five issues.
    sb_push(64'h0, 32'h38000001); sb_push(64'h4, 32'h38000002); sb_push(64'h8, 32'h38000003);
    sb_push(64'hC, 32'h38000004); sb_push(64'h10, 32'h38000005);
    tick(); reset = 1'b0; mid();
    chk("s1_c0_en", mem_rd_en, 1); chk("s1_c0_addr", mem_rd_addr, 0);
    tick(); mid();
    chk("s1_c1_en", mem_rd_en, 1); chk("s1_c1_addr", mem_rd_addr, 0); chk("s1_c1_dvalid", d_valid, 0);
    tick(); mid();
    chk("s1_c2_addr", mem_rd_addr, 1); chk("s1_c2_dvalid", d_valid, 1);
    chk("s1_c2_dpc", d_pc, 64'h0); chk("s1_c2_dinstr", d_instr, 32'h38000001);
    tick(); mid();
    chk("s1_c3_dpc", d_pc, 64'h4); chk("s1_c3_dinstr", d_instr, 32'h38000002);
    tick(); mid();
    chk("s1_c4_dpc", d_pc, 64'h8); chk("s1_c4_dinstr", d_instr, 32'h38000003);
    tick(); halt = 1'b1; mid();
    chk("s1_c5_en", mem_rd_en, 0);
    tick(); mid();
    tick(); mid();
    chk("s1_c7_dvalid", d_valid, 0);

    // Decode stalled from reset: fill, partially drain, refill to full.
    tick(); reset = 1'b1; halt = 1'b0; d_ready = 1'b0; mid();
    sb_push(64'h0, 32'h38000001); sb_push(64'h4, 32'h38000002);
    tick(); reset = 1'b0; mid();
    chk("s2_c0_addr", mem_rd_addr, 0); chk("s2_c0_en", mem_rd_en, 1);
    tick(); mid();
    chk("s2_c1_addr", mem_rd_addr, 0); chk("s2_c1_en", mem_rd_en, 1);
    tick(); mid();
    chk("s2_c2_addr", mem_rd_addr, 1); chk("s2_c2_en", mem_rd_en, 1);
    tick(); mid();
    chk("s2_c3_addr", mem_rd_addr, 1); chk("s2_c3_en", mem_rd_en, 1);
    tick(); mid();
    chk("s2_c4_en", mem_rd_en, 0);
    tick(); mid();
    chk("s2_c5_en", mem_rd_en, 0); chk("s2_c5_dvalid", d_valid, 1); chk("s2_c5_dpc", d_pc, 64'h0);
    tick(); d_ready = 1'b1; mid();
    chk("s2_c6_en", mem_rd_en, 0);
    tick(); mid();
    chk("s2_c7_en", mem_rd_en, 1); chk("s2_c7_addr", mem_rd_addr, 2); chk("s2_c7_dpc", d_pc, 64'h4);
    tick(); d_ready = 1'b0; mid();
    chk("s2_c8_dpc", d_pc, 64'h8);
    tick(); mid();
    chk("s2_c9_en", mem_rd_en, 0);

    // Redirect with a full queue; then redirect as the 0x40 response returns.
    sb_push(64'h100, 32'h38000041); sb_push(64'h104, 32'h38000042);
    sb_push(64'h200, 32'h38000081); sb_push(64'h204, 32'h38000082);
    tick(); redirect = 1'b1; redirect_pc = 64'h103; d_ready = 1'b1; mid();
    chk("s3_t0_dvalid", d_valid, 0); chk("s3_t0_en", mem_rd_en, 0);
    tick(); redirect = 1'b0; mid();
    chk("s3_t1_en", mem_rd_en, 1); chk("s3_t1_addr", mem_rd_addr, 61'h20); chk("s3_t1_dvalid", d_valid, 0);
    tick(); mid();
    chk("s3_t2_dvalid", d_valid, 0);
    tick(); mid();
    chk("s3_t3_dvalid", d_valid, 1); chk("s3_t3_dpc", d_pc, 64'h100);
    tick(); mid();
    tick(); redirect = 1'b1; redirect_pc = 64'h40; mid();
    chk("s4_r1_dvalid", d_valid, 0);
    tick(); redirect = 1'b0; mid();
    chk("s4_issue40_addr", mem_rd_addr, 61'h8); chk("s4_issue40_en", mem_rd_en, 1);
    tick(); redirect = 1'b1; redirect_pc = 64'h200; mid();
    chk("s4_r2_dvalid", d_valid, 0); chk("s4_r2_en", mem_rd_en, 0);
    tick(); redirect = 1'b0; mid();
    chk("s4_t1_addr", mem_rd_addr, 61'h40); chk("s4_t1_dvalid", d_valid, 0);
    tick(); mid();
    chk("s4_t2_dvalid", d_valid, 0);
    tick(); halt = 1'b1; mid();
    chk("s4_t3_dpc", d_pc, 64'h200); chk("s4_t3_en", mem_rd_en, 0);
    tick(); mid();
    tick(); mid();
    chk("s4_drained", d_valid, 0);

    // Halt with two queued and one in flight.
    sb_push(64'h208, 32'h38000083); sb_push(64'h20C, 32'h38000084);
    sb_push(64'h210, 32'h38000085); sb_push(64'h214, 32'h38000086);
    tick(); halt = 1'b0; d_ready = 1'b0; mid();
    chk("s5_a0_addr", mem_rd_addr, 61'h41);
    tick(); mid();
    chk("s5_a1_addr", mem_rd_addr, 61'h41);
    tick(); mid();
    chk("s5_a2_addr", mem_rd_addr, 61'h42);
    tick(); halt = 1'b1; d_ready = 1'b1; mid();
    chk("s5_h0_en", mem_rd_en, 0); chk("s5_h0_dpc", d_pc, 64'h208);
    tick(); mid();
    chk("s5_h1_en", mem_rd_en, 0);
    tick(); mid();
    chk("s5_h2_dpc", d_pc, 64'h210);
    tick(); mid();
    chk("s5_h3_dvalid", d_valid, 0); chk("s5_h3_en", mem_rd_en, 0);
    tick(); mid();
    chk("s5_h4_dvalid", d_valid, 0);
    tick(); halt = 1'b0; mid();
    chk("s5_resume_en", mem_rd_en, 1); chk("s5_resume_addr", mem_rd_addr, 61'h42);
    tick(); mid();
    tick(); mid();
    chk("s5_resume_dpc", d_pc, 64'h214);

    // Asynchronous reset between edges, then restart from PC 0.
    #2 reset = 1'b1;
    #1;
    chk("s6_rst_dvalid", d_valid, 0); chk("s6_rst_en", mem_rd_en, 0);
    chk("s6_rst_dpc", d_pc, 0); chk("s6_rst_addr", mem_rd_addr, 0);
    sb_push(64'h0, 32'h38000001); sb_push(64'h4, 32'h38000002); sb_push(64'h8, 32'h38000003);
    tick(); mid();
    tick(); reset = 1'b0; mid();
    chk("s6_c0_en", mem_rd_en, 1); chk("s6_c0_addr", mem_rd_addr, 0);
    tick(); mid();
    tick(); mid();
    chk("s6_c2_dpc", d_pc, 64'h0); chk("s6_c2_dvalid", d_valid, 1);
    tick(); halt = 1'b1; mid();
    tick(); mid();
    tick(); mid();
    chk("s6_done_dvalid", d_valid, 0);
    tick(); mid();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
